// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/shift ops and iterative signed MUL/DIV
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             cout,
    output logic             dz
);
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
    state_t st;
    logic [WIDTH-1:0] a_r, b_r, ma, acc, mq, res, abs_a, abs_b, dv;
    logic [SHW-1:0] cnt, amt, namt;
    logic [WIDTH:0] sum_s, sum, t;
    logic [2*WIDTH-1:0] prod;
    logic is_div, neg_q, neg_r, cy, bz;
    always_comb begin
        amt = B[SHW-1:0];
        namt = -amt;
        sum_s = {1'b0, A} + {1'b0, op == 5'd3 ? ~B : B} + {{WIDTH{1'b0}}, op == 5'd3};
        res = A & B;
        cy = 1'b0;
        case (op)
            5'd0: res = A | B;
            5'd2, 5'd3: {cy, res} = sum_s;
            5'd4: res = -A;
            5'd5: res = A >> amt;
            5'd6: res = A << amt;
            5'd7: res = (A >> amt) | (A << namt);
            5'd8: res = (A << amt) | (A >> namt);
            5'd9: res = $signed(A) >>> amt;
            default: res = A & B;
        endcase
        abs_a = a_r[WIDTH-1] ? -a_r : a_r;
        abs_b = b_r[WIDTH-1] ? -b_r : b_r;
        bz = b_r == '0;
        sum = {1'b0, acc} + (mq[0] ? {1'b0, ma} : '0);
        // restoring divide: shift next dividend bit into the partial remainder
        t = {acc, mq[WIDTH-1]};
        dv = t[WIDTH-1:0] - ma;
        prod = {acc, mq};
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            st <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            C <= '0;
            HI <= '0;
            LO <= '0;
            cout <= 1'b0;
            dz <= 1'b0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    if (op == 5'd10 || op == 5'd11) begin
                        st <= PREP;
                        busy <= 1'b1;
                        is_div <= op[0];
                        a_r <= A;
                        b_r <= B;
                    end else begin
                        st <= DONE;
                        done <= 1'b1;
                        C <= res;
                        cout <= cy;
                    end
                end
                PREP: begin
                    ma <= is_div ? abs_b : abs_a;
                    mq <= is_div ? abs_a : abs_b;
                    acc <= '0;
                    cnt <= SHW'(WIDTH - 1);
                    neg_q <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                    neg_r <= a_r[WIDTH-1];
                    st <= (is_div && bz) ? FIX : RUN;
                end
                RUN: begin
                    if (is_div) begin
                        acc <= (t >= {1'b0, ma}) ? dv : t[WIDTH-1:0];
                        mq <= {mq[WIDTH-2:0], t >= {1'b0, ma}};
                    end else begin
                        acc <= sum[WIDTH:1];
                        mq <= {sum[0], mq[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    st <= cnt == '0 ? FIX : RUN;
                end
                FIX: begin
                    if (is_div) begin
                        LO <= bz ? '1 : (neg_q ? -mq : mq);
                        HI <= bz ? a_r : (neg_r ? -acc : acc);
                        dz <= bz;
                    end else begin
                        {HI, LO} <= neg_q ? -prod : prod;
                    end
                    st <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                DONE: begin
                    done <= 1'b0;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the datapath. It keeps the single-cycle operation set with registered results, adds barrel shifts and rotates by a variable amount, and adds signed multiply and divide, both iterative. It sits between the A/B operand registers and the result registers: C goes to the C register, and HI/LO feed the HI and LO registers. The control unit drives it with a start/done handshake.

## Interface
- WIDTH, 32, operand/result width; must be a power of two and at least 8
- SHW, $clog2(WIDTH), shift-amount field width (derived, do not override)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  5  operation code, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; results valid from this cycle
- C  out  WIDTH  result for ops 0–9
- HI  out  WIDTH  MUL upper product or DIV remainder
- LO  out  WIDTH  MUL lower product or DIV quotient
- cout  out  1  carry out (ADD) or no-borrow (SUB); 0 for all other ops
- dz  out  1  divide-by-zero flag for the last DIV

## Operation
- Op codes:
  - 0 OR, 1 AND, 2 ADD A+B, 3 SUB A−B, 4 NEG −A (two's complement)
  - 5 SHR logical, 6 SHL, 7 ROR, 8 ROL, 9 SHRA arithmetic
  - For ops 5–9, shift/rotate amount = B[SHW-1:0]; an amount of 0 passes A through.
  - 10 MUL signed A×B: 2·WIDTH product in {HI,LO}
  - 11 DIV signed A÷B: quotient in LO, remainder in HI; truncates toward zero; remainder takes the sign of A
  - 12–31 are undefined: behave as AND, single-cycle
- FSM states: IDLE, PREP, RUN, FIX, DONE.
  - IDLE, start=1, op≤9 or op≥12: compute result into C (and cout), go to DONE.
  - IDLE, start=1, op 10/11: latch op, go to PREP.
  - PREP: take |A| and |B|, record the result sign, clear the accumulator, load the iteration counter with WIDTH−1. Go to RUN.
  - RUN: one shift-add step (MUL) or one restoring shift-subtract step (DIV) per cycle. When the counter reaches 0, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- MUL/DIV leave C unchanged. Ops 0–9 leave HI/LO unchanged.
- Divide by zero (B=0 at start):
  - Skip RUN and go PREP→FIX.
  - Result: LO=all ones, HI=A, dz=1.
  - Any other DIV clears dz. Non-DIV ops leave dz unchanged.
- DIV of the most negative value by −1: LO=most negative value, HI=0, dz=0. No trap.
- Outputs hold their values until overwritten by a later completing operation.

## Timing
- Reset (clr=1 at an edge), from any state including mid-RUN:
  - State=IDLE; busy=0, done=0, C=0, HI=0, LO=0, cout=0, dz=0.
  - The operation in flight is discarded and no done is issued.
- Latency, counted from the start edge to the edge at which done rises:
  - Single-cycle ops: 1 cycle. busy stays 0 for these ops.
  - MUL, or DIV with B≠0: WIDTH+3 cycles (PREP 1, RUN WIDTH, FIX 1, DONE 1). That is 35 cycles at WIDTH=32.
  - DIV with B=0: 3 cycles.
- busy=1 in PREP, RUN and FIX, and 0 in DONE.
- start is ignored while busy=1 or done=1; it is not queued.
- start in the cycle after done is accepted, giving back-to-back operation.
- A, B and op may change freely after the start cycle; the operands are held internally.
- If clr and start are high in the same cycle, clr wins.

## Test plan
- Reset: clr for 2 cycles mid-RUN of a MUL → all outputs 0, and no done pulse follows within 40 cycles.
- Logic and arithmetic, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → C=0, cout=1, done 1 cycle after start.
  - SUB 5−7 → C=0xFFFFFFFE, cout=0.
  - NEG 1 → C=0xFFFFFFFF.
- Shifts, A=0x80000001:
  - SHR, B=4 → 0x08000000
  - SHRA, B=4 → 0xF8000000
  - ROL, B=1 → 0x00000003
  - ROR, B=33 (amount 1) → 0xC0000000
  - SHL, B=0 → 0x80000001
- MUL:
  - −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB, done exactly 35 cycles after start.
  - 0x7FFFFFFF×0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
- DIV:
  - −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, dz=0.
  - 9÷0 → LO=0xFFFFFFFF, HI=9, dz=1, done 3 cycles after start.
  - 0x80000000÷−1 → LO=0x80000000, HI=0.
- Handshake:
  - start pulsed during RUN with op=ADD → ignored; C unchanged.
  - start in the cycle after done → accepted.
  - Sweep WIDTH=8 and WIDTH=16 with random MUL/DIV against a reference model.
